// File: rtl/core_irq_ctrl.sv
// Interrupt conditioning front end: per-source level/edge mode, mask and W1C pending latch.
// Optional input synchroniser enabled by defining CORE_IRQ_SYNC_EN.
module core_irq_ctrl #(
    parameter int NumIrqs    = 16,
    parameter int SyncStages = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NumIrqs-1:0] irqs_i,
    input  logic               reg_req_i,
    input  logic               reg_we_i,
    input  logic [3:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic               reg_rvalid_o,
    output logic [31:0]        reg_rdata_o,
    output logic [15:0]        irq_fast_o,
    output logic               irq_any_o
);

    localparam int N = NumIrqs;

    logic [N-1:0] s;
    logic [N-1:0] p;
    logic [N-1:0] mask;
    logic [N-1:0] mode;
    logic [N-1:0] pending;
    logic [N-1:0] mask_d;
    logic [N-1:0] mode_d;
    logic [N-1:0] pending_d;
    logic [N-1:0] clr_w1c;
    logic [N-1:0] set_edge;
    logic [N-1:0] to_edge;
    logic [31:0]  rd_val;
    logic         wr;
    logic [1:0]   sel;
    logic         unused_bits;

`ifdef CORE_IRQ_SYNC_EN
    logic [SyncStages-1:0][N-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], irqs_i};
        end
    end

    assign s = sync_q[SyncStages-1];
`else
    assign s = irqs_i;
`endif

    assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i[31:N]} ^ (SyncStages != 0);

    // Register port: every request is accepted in its own cycle and answered by
    // reg_rvalid_o exactly one cycle later; reads return pre-update register values.
    assign wr  = reg_req_i & reg_we_i;
    assign sel = reg_addr_i[3:2];

    always_comb begin
        mask_d  = mask;
        mode_d  = mode;
        clr_w1c = '0;
        if (wr) begin
            case (sel)
                2'd0:    mask_d  = reg_wdata_i[N-1:0];
                2'd1:    mode_d  = reg_wdata_i[N-1:0];
                2'd2:    clr_w1c = reg_wdata_i[N-1:0];
                default: ;
            endcase
        end
    end

    assign set_edge = s & ~p;
    assign to_edge  = mode_d & ~mode;

    // Edge channels: a detected edge beats a same-cycle W1C; switching into edge mode clears.
    always_comb begin
        pending_d = pending;
        for (int i = 0; i < N; i++) begin
            if (to_edge[i]) begin
                pending_d[i] = 1'b0;
            end else if (mode[i]) begin
                pending_d[i] = set_edge[i] | (pending[i] & ~clr_w1c[i]);
            end else begin
                pending_d[i] = s[i];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            2'd0:    rd_val[N-1:0] = mask;
            2'd1:    rd_val[N-1:0] = mode;
            2'd2:    rd_val[N-1:0] = pending;
            default: rd_val[N-1:0] = s;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask         <= '0;
            mode         <= '0;
            pending      <= '0;
            p            <= '0;
            reg_rvalid_o <= 1'b0;
            reg_rdata_o  <= '0;
        end else begin
            mask         <= mask_d;
            mode         <= mode_d;
            pending      <= pending_d;
            p            <= s;
            reg_rvalid_o <= reg_req_i;
            reg_rdata_o  <= (reg_req_i && !reg_we_i) ? rd_val : 32'h0;
        end
    end

    always_comb begin
        irq_fast_o        = '0;
        irq_fast_o[N-1:0] = pending & mask;
    end

    assign irq_any_o = |irq_fast_o;

endmodule
